// File: rtl/spi_reg_bridge_mc.sv
// SPI byte-stream to multi-channel register/FIFO bridge with channel select and burst access.
// Optional mid-frame idle timeout enabled by defining SPI_BRIDGE_TIMEOUT_EN.
module spi_reg_bridge_mc #(
  parameter int NUM_CH      = 4,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rstn_async,
  input  logic [7:0]            spi_data,
  input  logic                  spi_valid,
  output logic [7:0]            spi_data_out,
  output logic                  spi_tx_valid,
  output logic [6:0]            ch_addr,
  output logic [7:0]            ch_wdata,
  output logic [NUM_CH-1:0]     ch_we,
  input  logic [NUM_CH*8-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]     ch_fifo_rd,
  input  logic [NUM_CH*8-1:0]   ch_fifo_data,
  output logic                  err
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_TAIL} state_e;

  localparam logic [3:0] OP_SREG  = 4'h9;
  localparam logic [3:0] OP_SFIFO = 4'hA;
  localparam logic [3:0] OP_BREG  = 4'hB;
  localparam logic [3:0] OP_BFIFO = 4'hC;

  state_e              state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic [3:0]          op_q, op_d;
  logic                rw_q, rw_d;
  logic [6:0]          addr_q, addr_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [RD_LAT-1:0]   pend_q, pend_d;
  logic                src_fifo_q, src_fifo_d;
  logic [6:0]          ch_addr_q, ch_addr_d;
  logic [7:0]          ch_wdata_q, ch_wdata_d;
  logic [NUM_CH-1:0]   we_q, we_d;
  logic [NUM_CH-1:0]   pop_q, pop_d;
  logic                err_q, err_d;
  logic                txv_q, txv_d;
  logic [7:0]          txd_q, txd_d;
`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]       tmo_q, tmo_d;
`endif

  logic              issue;
  logic [7:0]        rsel, fsel;
  logic [NUM_CH-1:0] ch_oh, cmd_oh;
  logic              cmd_ok, last;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    op_d       = op_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    src_fifo_d = src_fifo_q;
    ch_addr_d  = ch_addr_q;
    ch_wdata_d = ch_wdata_q;
    txd_d      = txd_q;
    we_d       = '0;
    pop_d      = '0;
    err_d      = 1'b0;
    txv_d      = 1'b0;
    issue      = 1'b0;
    rsel       = 8'h00;
    fsel       = 8'h00;
    last       = (cnt_q == 9'd1);
    ch_oh      = NUM_CH'(1) << ch_q;
    cmd_oh     = NUM_CH'(1) << spi_data[6:4];
    cmd_ok     = spi_data[7] && ({29'd0, spi_data[6:4]} < NUM_CH) &&
                 (spi_data[3:0] >= OP_SREG) && (spi_data[3:0] <= OP_BFIFO);

    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == 3'(k)) begin
        rsel = ch_rdata[8*k +: 8];
        fsel = ch_fifo_data[8*k +: 8];
      end
    end

    // Read pipeline: capture lands RD_LAT cycles after the registered address/pop
    if (pend_q[RD_LAT-1]) begin
      txv_d = 1'b1;
      txd_d = src_fifo_q ? fsel : rsel;
    end

    if (spi_valid) begin
      case (state_q)
        S_IDLE: begin
          if (cmd_ok) begin
            ch_d = spi_data[6:4];
            op_d = spi_data[3:0];
            case (spi_data[3:0])
              OP_SFIFO: begin
                pop_d      = cmd_oh;
                issue      = 1'b1;
                src_fifo_d = 1'b1;
                cnt_d      = 9'd2;
                state_d    = S_TAIL;
              end
              OP_BFIFO: state_d = S_LEN;
              default:  state_d = S_ADDR;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
        S_ADDR: begin
          rw_d   = spi_data[7];
          addr_d = spi_data[6:0];
          if (op_q == OP_SREG) begin
            state_d = S_DATA;
            if (!spi_data[7]) begin
              ch_addr_d  = spi_data[6:0];
              issue      = 1'b1;
              src_fifo_d = 1'b0;
            end
          end else begin
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          cnt_d   = (spi_data == 8'h00) ? 9'd256 : {1'b0, spi_data};
          state_d = S_DATA;
          if (op_q == OP_BFIFO) begin
            pop_d      = ch_oh;
            issue      = 1'b1;
            src_fifo_d = 1'b1;
          end else if (!rw_q) begin
            ch_addr_d  = addr_q;
            addr_d     = addr_q + 7'd1;
            issue      = 1'b1;
            src_fifo_d = 1'b0;
          end
        end
        S_DATA: begin
          if (op_q == OP_SREG) begin
            if (rw_q) begin
              ch_addr_d  = addr_q;
              ch_wdata_d = spi_data;
              we_d       = ch_oh;
            end
            cnt_d   = 9'd1;
            state_d = S_TAIL;
          end else begin
            cnt_d = cnt_q - 9'd1;
            if (last) state_d = S_IDLE;
            if (op_q == OP_BFIFO) begin
              if (!last) begin
                pop_d      = ch_oh;
                issue      = 1'b1;
                src_fifo_d = 1'b1;
              end
            end else if (rw_q) begin
              ch_addr_d  = addr_q;
              ch_wdata_d = spi_data;
              we_d       = ch_oh;
              addr_d     = addr_q + 7'd1;
            end else if (!last) begin
              ch_addr_d  = addr_q;
              addr_d     = addr_q + 7'd1;
              issue      = 1'b1;
              src_fifo_d = 1'b0;
            end
          end
        end
        S_TAIL: begin
          cnt_d = cnt_q - 9'd1;
          if (last) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    pend_d = (pend_q << 1) | RD_LAT'(issue);

`ifdef SPI_BRIDGE_TIMEOUT_EN
    tmo_d = '0;
    if (state_q != S_IDLE && !spi_valid) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        pend_d  = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      op_q       <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      src_fifo_q <= 1'b0;
      ch_addr_q  <= '0;
      ch_wdata_q <= '0;
      we_q       <= '0;
      pop_q      <= '0;
      err_q      <= 1'b0;
      txv_q      <= 1'b0;
      txd_q      <= '0;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      op_q       <= op_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      src_fifo_q <= src_fifo_d;
      ch_addr_q  <= ch_addr_d;
      ch_wdata_q <= ch_wdata_d;
      we_q       <= we_d;
      pop_q      <= pop_d;
      err_q      <= err_d;
      txv_q      <= txv_d;
      txd_q      <= txd_d;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign spi_data_out = txd_q;
  assign spi_tx_valid = txv_q;
  assign ch_addr      = ch_addr_q;
  assign ch_wdata     = ch_wdata_q;
  assign ch_we        = we_q;
  assign ch_fifo_rd   = pop_q;
  assign err          = err_q;

endmodule

// File: tb/tb_spi_reg_bridge_mc.sv
// Directed bench for spi_reg_bridge_mc: per-byte vector table plus async-reset and timeout sequences.
module tb_spi_reg_bridge_mc;

  logic        clk = 1'b0;
  logic        rstn_async;
  logic [7:0]  spi_data;
  logic        spi_valid;
  logic [7:0]  spi_data_out;
  logic        spi_tx_valid;
  logic [6:0]  ch_addr;
  logic [7:0]  ch_wdata;
  logic [3:0]  ch_we;
  logic [31:0] ch_rdata;
  logic [3:0]  ch_fifo_rd;
  logic [31:0] ch_fifo_data;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // Channel 0 FIFO is first-word-fall-through: head is 0xF0 + number of pops so far
  logic [7:0] pop0 = 8'd0;
  logic [7:0] f0;
  assign f0           = 8'hF0 + pop0;
  assign ch_fifo_data = {24'h0, f0};
  assign ch_rdata     = {8'hD3, 8'h5A, 8'hC1, 8'hB0};

  always_ff @(posedge clk) if (ch_fifo_rd[0]) pop0 <= pop0 + 8'd1;

  always #5 clk = ~clk;

  spi_reg_bridge_mc #(.NUM_CH(4), .RD_LAT(1), .TIMEOUT_CYC(4096)) dut (
    .clk(clk), .rstn_async(rstn_async), .spi_data(spi_data), .spi_valid(spi_valid),
    .spi_data_out(spi_data_out), .spi_tx_valid(spi_tx_valid), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_we(ch_we), .ch_rdata(ch_rdata), .ch_fifo_rd(ch_fifo_rd),
    .ch_fifo_data(ch_fifo_data), .err(err)
  );

  typedef struct {
    logic [7:0] b;
    logic [3:0] we;
    logic       ac;
    logic [6:0] addr;
    logic [7:0] wd;
    logic [3:0] pop;
    logic       er;
    logic       tx;
    logic [7:0] txd;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b, input logic [3:0] we, input logic ac,
                              input logic [6:0] addr, input logic [7:0] wd, input logic [3:0] pop,
                              input logic er, input logic tx, input logic [7:0] txd);
    vec_t v;
    v.b = b; v.we = we; v.ac = ac; v.addr = addr; v.wd = wd;
    v.pop = pop; v.er = er; v.tx = tx; v.txd = txd;
    return v;
  endfunction

  function automatic vec_t nop(input logic [7:0] b);
    return mk(b, 4'h0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One byte per 4 cycles; observe t+1 (strobes), t+2 (capture) and t+3 (quiet)
  task automatic apply(input vec_t v, input string nm);
    logic [3:0] we1, pop1, we2, pop2;
    logic       err1, err2, txv1, txv2, txv3;
    logic [6:0] a1;
    logic [7:0] wd1, txd2;
    @(posedge clk); #1;
    spi_data = v.b; spi_valid = 1'b1;
    @(posedge clk); #1;
    spi_valid = 1'b0;
    we1 = ch_we; pop1 = ch_fifo_rd; err1 = err; a1 = ch_addr; wd1 = ch_wdata; txv1 = spi_tx_valid;
    @(posedge clk); #1;
    we2 = ch_we; pop2 = ch_fifo_rd; err2 = err; txv2 = spi_tx_valid; txd2 = spi_data_out;
    @(posedge clk); #1;
    txv3 = spi_tx_valid;
    chk({nm, "_we"},  64'(we1),  64'(v.we));
    chk({nm, "_pop"}, 64'(pop1), 64'(v.pop));
    chk({nm, "_err"}, 64'(err1), 64'(v.er));
    chk({nm, "_txv"}, 64'(txv2), 64'(v.tx));
    chk({nm, "_quiet"}, 64'({we2, pop2, err2, txv1, txv3}), 64'd0);
    if (v.ac) chk({nm, "_addr"}, 64'(a1), 64'(v.addr));
    if (v.we != 4'h0) chk({nm, "_wdata"}, 64'(wd1), 64'(v.wd));
    if (v.tx) chk({nm, "_txd"}, 64'(txd2), 64'(v.txd));
  endtask

  vec_t vt[$];

  initial begin
    // Single write ch0, single read ch2, burst write wrap ch1
    vt.push_back(nop(8'h89)); vt.push_back(nop(8'hA4));
    vt.push_back(mk(8'h02, 4'b0001, 1'b1, 7'h24, 8'h02, 4'h0, 1'b0, 1'b0, 8'h00));
    vt.push_back(nop(8'h00));
    vt.push_back(nop(8'hA9));
    vt.push_back(mk(8'h24, 4'h0, 1'b1, 7'h24, 8'h00, 4'h0, 1'b0, 1'b1, 8'h5A));
    vt.push_back(nop(8'h00)); vt.push_back(nop(8'h00));
    vt.push_back(nop(8'h9B)); vt.push_back(nop(8'hFE)); vt.push_back(nop(8'h03));
    vt.push_back(mk(8'h11, 4'b0010, 1'b1, 7'h7E, 8'h11, 4'h0, 1'b0, 1'b0, 8'h00));
    vt.push_back(mk(8'h22, 4'b0010, 1'b1, 7'h7F, 8'h22, 4'h0, 1'b0, 1'b0, 8'h00));
    vt.push_back(mk(8'h33, 4'b0010, 1'b1, 7'h00, 8'h33, 4'h0, 1'b0, 1'b0, 8'h00));
    // Burst FIFO ch0 L=4
    vt.push_back(nop(8'h8C));
    vt.push_back(mk(8'h04, 4'h0, 1'b0, 7'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 8'hF0));
    vt.push_back(mk(8'hAA, 4'h0, 1'b0, 7'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 8'hF1));
    vt.push_back(mk(8'hAA, 4'h0, 1'b0, 7'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 8'hF2));
    vt.push_back(mk(8'hAA, 4'h0, 1'b0, 7'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 8'hF3));
    vt.push_back(nop(8'hAA));
    // Rejects then single FIFO pop
    vt.push_back(mk(8'h49, 4'h0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00));
    vt.push_back(mk(8'hF9, 4'h0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00));
    vt.push_back(mk(8'h85, 4'h0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00));
    vt.push_back(mk(8'h8A, 4'h0, 1'b0, 7'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 8'hF4));
    vt.push_back(nop(8'h00)); vt.push_back(nop(8'h00));
    // Burst read ch3 from 0x7F, L=2, address wraps
    vt.push_back(nop(8'hBB)); vt.push_back(nop(8'h7F));
    vt.push_back(mk(8'h02, 4'h0, 1'b1, 7'h7F, 8'h00, 4'h0, 1'b0, 1'b1, 8'hD3));
    vt.push_back(mk(8'h00, 4'h0, 1'b1, 7'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'hD3));
    vt.push_back(nop(8'h00));

    spi_data = 8'h00; spi_valid = 1'b0; rstn_async = 1'b0;
    #1;
    chk("reset_outputs", 64'({spi_data_out, spi_tx_valid, ch_addr, ch_wdata, ch_we, ch_fifo_rd, err}), 64'd0);
    repeat (3) @(negedge clk);
    rstn_async = 1'b1;

    foreach (vt[i]) apply(vt[i], $sformatf("v%0d", i));

    // Async reset mid-burst write: strobe visible, then reset clears outputs without a clock edge
    apply(nop(8'h9B), "rb_cmd");
    apply(nop(8'h80), "rb_addr");
    apply(nop(8'h05), "rb_len");
    @(posedge clk); #1;
    spi_data = 8'h66; spi_valid = 1'b1;
    @(posedge clk); #1;
    spi_valid = 1'b0;
    chk("rb_we_before", 64'({ch_we, ch_wdata}), 64'({4'b0010, 8'h66}));
    #2 rstn_async = 1'b0;
    #1;
    chk("rb_async_clear", 64'({spi_data_out, spi_tx_valid, ch_addr, ch_wdata, ch_we, ch_fifo_rd, err}), 64'd0);
    @(negedge clk);
    rstn_async = 1'b1;
    apply(nop(8'h89), "rb_new_cmd");
    apply(nop(8'hC5), "rb_new_addr");
    apply(mk(8'h77, 4'b0001, 1'b1, 7'h45, 8'h77, 4'h0, 1'b0, 1'b0, 8'h00), "rb_new_data");
    apply(nop(8'h00), "rb_new_tail");

`ifdef SPI_BRIDGE_TIMEOUT_EN
    begin
      int seen = 0;
      apply(nop(8'h89), "tmo_cmd");
      for (int c = 0; c < 4096 + 16 && seen == 0; c++) begin
        @(posedge clk); #1;
        if (err) seen = 1;
      end
      chk("tmo_err", 64'(seen), 64'd1);
      apply(mk(8'h8A, 4'h0, 1'b0, 7'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 8'hF5), "tmo_idle_pop");
      apply(nop(8'h00), "tmo_d1");
      apply(nop(8'h00), "tmo_d2");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_reg_bridge_mc.md
Name: spi_reg_bridge_mc

Overview:
- Multi-channel successor to the single-target SPI link state machine.
- Parses the byte stream from the SPI slave (byte + valid strobe) into register read/write and FIFO-pop transactions on NUM_CH peripheral channels (SD controller on ch0, further controllers on ch1..).
- Adds channel select, auto-incrementing burst register access, burst FIFO drain and an error strobe.
- Returns read data to the SPI slave TX path (byte + one-cycle tx valid).

Parameters:
- NUM_CH, 4, number of peripheral channels, legal 1..8.
- RD_LAT, 1, cycles from ch_addr/ch_fifo_rd update to valid ch_rdata/ch_fifo_data, legal 1..3.
- TIMEOUT_CYC, 4096, idle clk cycles mid-frame before abort (optional feature only).

Ports:
- clk  in  1  system clock
- rstn_async  in  1  asynchronous active-low reset
- spi_data  in  8  received SPI byte, valid only when spi_valid=1
- spi_valid  in  1  one-cycle strobe per received byte
- spi_data_out  out  8  byte to load into SPI TX
- spi_tx_valid  out  1  one-cycle load strobe for spi_data_out
- ch_addr  out  7  shared register address
- ch_wdata  out  8  shared write data
- ch_we  out  NUM_CH  one-hot write strobe
- ch_rdata  in  NUM_CH*8  per-channel register read data, ch k at [8k+7:8k]
- ch_fifo_rd  out  NUM_CH  one-hot FIFO pop strobe
- ch_fifo_data  in  NUM_CH*8  per-channel FIFO data
- err  out  1  one-cycle strobe on rejected command byte

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Reset mid-frame aborts the frame; no strobes are issued.
- Command byte: cmd[7]=1, cmd[6:4]=ch, cmd[3:0]=op.
  - op 9 = single reg, A = single FIFO pop, B = burst reg, C = burst FIFO.
  - cmd[7]=0, ch>=NUM_CH or any other op: err pulses at t+1, stay IDLE, byte discarded.
- Timing reference t = cycle spi_valid is seen. All strobes are registered: ch_we/ch_fifo_rd pulse exactly 1 cycle at t+1. Read data is captured at t+1+RD_LAT; spi_tx_valid pulses that cycle with spi_data_out = captured byte. spi_data_out holds its value until the next load.
- States: IDLE, ADDR, LEN, DATA, TAIL.
- Single reg (op 9), 4 bytes: cmd, {rw,addr[6:0]}, data, dummy.
  - rw=1: ch_addr/ch_wdata set and ch_we[ch] pulses at t+1 of the data byte.
  - rw=0: read issued on the addr byte; the response shifts out during byte 3.
  - Byte 4 returns the engine to IDLE.
- Single FIFO (op A), 3 bytes: cmd, dummy, dummy. Pop on the cmd byte; data returned during byte 2; IDLE after byte 3.
- Burst reg (op B): cmd, {rw,addr}, L, then L data bytes; L=0 means 256.
  - Write: each data byte writes at the current address, then address+1.
  - Read: first read issued on the L byte, next read on each data byte except the last.
  - Address wraps 127->0. IDLE after the L-th data byte.
- Burst FIFO (op C): cmd, L, then L bytes. Pops on the L byte and on data bytes 1..L-1 (exactly L pops total). IDLE after the L-th data byte.
- Pops on an empty downstream FIFO are not detected; data returned as presented.
- Environment precondition: spi_valid spacing >= RD_LAT+2 cycles. The bridge is not required to behave correctly below this.
- spi_valid in the same cycle as a pending capture: capture completes first; the new byte is processed normally.

Optional Feature:
- Macro SPI_BRIDGE_TIMEOUT_EN.
- With it: a counter increments every cycle while state!=IDLE and spi_valid=0, and clears on spi_valid. When it reaches TIMEOUT_CYC, state returns to IDLE and err pulses once; pending strobes are not issued.
- Without it: the engine waits indefinitely mid-frame and the counter is absent.

Test Plan:
- Reset: rstn_async low mid-burst -> all outputs 0 within 0 cycles (async); next byte 0x89 is parsed as a new command.
- Single write ch0: 0x89,0xA4,0x02,0x00 -> ch_we=0001 one cycle, ch_addr=0x24, ch_wdata=0x02; returns to IDLE.
- Single read ch2 (ch_rdata[23:16]=0x5A, RD_LAT=1): 0xA9,0x24,0x00,0x00 -> spi_tx_valid 2 cycles after the addr byte with spi_data_out=0x5A; no ch_we.
- Burst write wrap ch1: 0x9B,0xFE,0x03,0x11,0x22,0x33 -> writes 0x11@0x7E, 0x22@0x7F, 0x33@0x00, ch_we=0010 each time.
- Burst FIFO ch0, L=4: 0x8C,0x04, then 4 bytes -> exactly 4 ch_fifo_rd[0] pulses and 4 spi_tx_valid pulses carrying FIFO bytes in order.
- Rejects: 0x49 and 0xF9 (NUM_CH=4) -> err pulses once per byte; no strobes; next 0x8A pops ch0. With the macro defined: stall after 0x89 for TIMEOUT_CYC -> err pulses, state returns to IDLE.
